mips_id_ex_mem: RTL and testbench

Decode, execute and memory-access stages of the 32-bit five-stage MIPS core, packaged as one pipelined block. It sits between the fetch register (instruction word, PC+4, valid) and the write-back stage. It drives the register-file read ports and the data-cache port, and returns jump and branch redirects to fetch. It has no hazard interlocks or forwarding; the compiler schedules around them.

---
 rtl/mips_id_ex_mem_if.sv | 50 +++++
 rtl/mips_id_ex_mem.sv | 200 ++++++++++++++++++++
 tb/tb_mips_id_ex_mem.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_id_ex_mem_if.sv
// Bus between the fetch register, register file, data cache and the
// ID/EX/MEM pipeline block. The pipeline uses the slave view; the fetch side
// and its environment use the master view.
interface mips_id_ex_mem_if;
  // Fetch register
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        valid_in;
  // Register-file read ports
  logic [4:0]  rfReadAddr_p0;
  logic [4:0]  rfReadAddr_p1;
  logic        rfReadEn_p0;
  logic        rfReadEn_p1;
  logic [31:0] rfReadData_p0;
  logic [31:0] rfReadData_p1;
  // Redirects back to fetch
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  // Data-cache port
  logic [31:0] dCacheAddr;
  logic [31:0] dCacheWriteData;
  logic        dCacheWriteEn;
  logic        dCacheReadEn;
  logic [31:0] dCacheReadData;
  // Write-back stage
  logic [31:0] wb_result;
  logic [31:0] wb_load_data;
  logic [4:0]  wb_dest;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        wb_valid;

  modport slave (
    input  instr_in, pc_in, valid_in, rfReadData_p0, rfReadData_p1, dCacheReadData,
    output rfReadAddr_p0, rfReadAddr_p1, rfReadEn_p0, rfReadEn_p1,
           jump_taken, jump_target, branch_taken, branch_target,
           dCacheAddr, dCacheWriteData, dCacheWriteEn, dCacheReadEn,
           wb_result, wb_load_data, wb_dest, wb_reg_write, wb_mem_to_reg, wb_valid
  );

  modport master (
    output instr_in, pc_in, valid_in, rfReadData_p0, rfReadData_p1, dCacheReadData,
    input  rfReadAddr_p0, rfReadAddr_p1, rfReadEn_p0, rfReadEn_p1,
           jump_taken, jump_target, branch_taken, branch_target,
           dCacheAddr, dCacheWriteData, dCacheWriteEn, dCacheReadEn,
           wb_result, wb_load_data, wb_dest, wb_reg_write, wb_mem_to_reg, wb_valid
  );
endinterface

// File: rtl/mips_id_ex_mem.sv
// Decode, execute and memory stages of the five-stage MIPS core. Three
// pipeline registers (ID/EX, EX/MEM, MEM/WB); no interlocks or forwarding.
module mips_id_ex_mem (
  input logic            clk,
  input logic            rst,
  mips_id_ex_mem_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_t;

  typedef struct packed {
    logic        valid;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        reg_write;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [25:0] target;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        is_lw;
    logic        is_sw;
    logic        branch_taken;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] branch_target;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] load_data;
  } mem_wb_t;

  id_ex_t  dec, id_ex;
  ex_mem_t ex_next, ex_mem;
  mem_wb_t wb_next, mem_wb;

  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic [31:0] op_b, alu_result, diff;

  assign opcode = bus.instr_in[31:26];
  assign funct  = bus.instr_in[5:0];
  assign imm16  = bus.instr_in[15:0];

  assign bus.rfReadAddr_p0 = bus.instr_in[25:21];
  assign bus.rfReadAddr_p1 = bus.instr_in[20:16];
  assign bus.rfReadEn_p0   = 1'b1;
  assign bus.rfReadEn_p1   = 1'b1;

  // Decode the fetch-register instruction into ID/EX controls.
  always_comb begin
    // NOTE: every field gets a default first so no path through the case leaves a latch.
    dec         = '0;
    dec.valid   = 1'b1;
    dec.pc      = bus.pc_in;
    dec.rs_val  = bus.rfReadData_p0;
    dec.rt_val  = bus.rfReadData_p1;
    dec.shamt   = bus.instr_in[10:6];
    dec.target  = bus.instr_in[25:0];
    dec.imm     = {{16{imm16[15]}}, imm16};
    dec.dest    = bus.instr_in[20:16];
    case (opcode)
      6'h00: begin
        dec.dest      = bus.instr_in[15:11];
        dec.reg_write = 1'b1;
        case (funct)
          6'h00:        dec.alu_op = ALU_SLL;
          6'h02:        dec.alu_op = ALU_SRL;
          6'h03:        dec.alu_op = ALU_SRA;
          6'h20, 6'h21: dec.alu_op = ALU_ADD;
          6'h22, 6'h23: dec.alu_op = ALU_SUB;
          6'h24:        dec.alu_op = ALU_AND;
          6'h25:        dec.alu_op = ALU_OR;
          6'h26:        dec.alu_op = ALU_XOR;
          6'h27:        dec.alu_op = ALU_NOR;
          6'h2A:        dec.alu_op = ALU_SLT;
          6'h2B:        dec.alu_op = ALU_SLTU;
          default:      dec.reg_write = 1'b0;
        endcase
      end
      6'h02: dec.is_j   = 1'b1;
      6'h04: begin dec.is_beq = 1'b1; dec.alu_op = ALU_SUB; end
      6'h05: begin dec.is_bne = 1'b1; dec.alu_op = ALU_SUB; end
      6'h08, 6'h09: begin dec.alu_op = ALU_ADD; dec.use_imm = 1'b1; dec.reg_write = 1'b1; end
      6'h0A: begin dec.alu_op = ALU_SLT; dec.use_imm = 1'b1; dec.reg_write = 1'b1; end
      6'h0C: begin dec.alu_op = ALU_AND; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.imm = {16'h0, imm16}; end
      6'h0D: begin dec.alu_op = ALU_OR;  dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.imm = {16'h0, imm16}; end
      6'h0E: begin dec.alu_op = ALU_XOR; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.imm = {16'h0, imm16}; end
      6'h0F: begin dec.alu_op = ALU_PASS_B; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.imm = {imm16, 16'h0}; end
      6'h23: begin dec.alu_op = ALU_ADD; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.is_lw = 1'b1; end
      6'h2B: begin dec.alu_op = ALU_ADD; dec.use_imm = 1'b1; dec.is_sw = 1'b1; end
      default: ;
    endcase
    // $0 is hard-wired; a write to it is dropped at decode.
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
    // A bubble carries nothing downstream.
    if (!bus.valid_in) dec = '0;
  end

  // EX-stage ALU; shifts act on rt, address arithmetic on rs + imm.
  assign op_b = id_ex.use_imm ? id_ex.imm : id_ex.rt_val;
  assign diff = id_ex.rs_val - id_ex.rt_val;

  always_comb begin
    alu_result = '0;
    case (id_ex.alu_op)
      ALU_ADD:    alu_result = id_ex.rs_val + op_b;
      ALU_SUB:    alu_result = id_ex.rs_val - op_b;
      ALU_AND:    alu_result = id_ex.rs_val & op_b;
      ALU_OR:     alu_result = id_ex.rs_val | op_b;
      ALU_XOR:    alu_result = id_ex.rs_val ^ op_b;
      ALU_NOR:    alu_result = ~(id_ex.rs_val | op_b);
      ALU_SLT:    alu_result = {31'd0, $signed(id_ex.rs_val) < $signed(op_b)};
      ALU_SLTU:   alu_result = {31'd0, id_ex.rs_val < op_b};
      ALU_SLL:    alu_result = op_b << id_ex.shamt;
      ALU_SRL:    alu_result = op_b >> id_ex.shamt;
      ALU_SRA:    alu_result = $unsigned($signed(op_b) >>> id_ex.shamt);
      ALU_PASS_B: alu_result = op_b;
      default:    alu_result = '0;
    endcase
  end

  // Assemble the EX/MEM payload, including the branch decision.
  always_comb begin
    ex_next               = '0;
    ex_next.valid         = id_ex.valid;
    ex_next.reg_write     = id_ex.reg_write;
    ex_next.is_lw         = id_ex.is_lw;
    ex_next.is_sw         = id_ex.is_sw;
    ex_next.dest          = id_ex.dest;
    ex_next.alu_result    = alu_result;
    ex_next.store_data    = id_ex.is_sw ? id_ex.rt_val : 32'd0;
    ex_next.branch_taken  = (id_ex.is_beq && diff == 32'd0) || (id_ex.is_bne && diff != 32'd0);
    ex_next.branch_target = id_ex.pc + {id_ex.imm[29:0], 2'b00};
  end

  // Assemble the MEM/WB payload; load data is only kept for LW.
  always_comb begin
    wb_next            = '0;
    wb_next.valid      = ex_mem.valid;
    wb_next.reg_write  = ex_mem.reg_write;
    wb_next.mem_to_reg = ex_mem.is_lw;
    wb_next.dest       = ex_mem.dest;
    wb_next.result     = ex_mem.alu_result;
    wb_next.load_data  = ex_mem.is_lw ? bus.dCacheReadData : 32'd0;
  end

  // Pipeline registers; reset discards every in-flight instruction.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch with no rst in the sensitivity list.
    if (!rst) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      // NOTE: non-blocking assignments let all three stages shift on the same edge without ordering effects.
      id_ex  <= dec;
      ex_mem <= ex_next;
      mem_wb <= wb_next;
    end
  end

  assign bus.jump_taken      = id_ex.valid & id_ex.is_j;
  assign bus.jump_target     = {id_ex.pc[31:28], id_ex.target, 2'b00};
  assign bus.branch_taken    = ex_mem.valid & ex_mem.branch_taken;
  assign bus.branch_target   = ex_mem.branch_target;
  assign bus.dCacheAddr      = ex_mem.alu_result;
  assign bus.dCacheWriteData = ex_mem.store_data;
  assign bus.dCacheWriteEn   = ex_mem.valid & ex_mem.is_sw;
  assign bus.dCacheReadEn    = ex_mem.valid & ex_mem.is_lw;

  assign bus.wb_result     = mem_wb.result;
  assign bus.wb_load_data  = mem_wb.load_data;
  assign bus.wb_dest       = mem_wb.dest;
  assign bus.wb_reg_write  = mem_wb.reg_write;
  assign bus.wb_mem_to_reg = mem_wb.mem_to_reg;
  assign bus.wb_valid      = mem_wb.valid;

endmodule

// File: tb/tb_mips_id_ex_mem.sv
// Directed-vector bench for mips_id_ex_mem. The bench acts as fetch register,
// register file and data cache; expected values are hand-computed.
module tb_mips_id_ex_mem;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mips_id_ex_mem_if bus ();

  mips_id_ex_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, shamt, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge (E0), then a bubble.
  task automatic issue(input logic [31:0] ins, pc, rs_d, rt_d);
    bus.instr_in      = ins;
    bus.pc_in         = pc;
    bus.rfReadData_p0 = rs_d;
    bus.rfReadData_p1 = rt_d;
    bus.valid_in      = 1'b1;
    tick();
    bus.valid_in      = 1'b0;
    bus.instr_in      = 32'h0;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] dest, input logic [31:0] res, input logic wr);
    check({tag, ".valid"}, {31'd0, bus.wb_valid}, 32'd1);
    check({tag, ".dest"},  {27'd0, bus.wb_dest}, {27'd0, dest});
    check({tag, ".result"}, bus.wb_result, res);
    check({tag, ".reg_write"}, {31'd0, bus.wb_reg_write}, {31'd0, wr});
  endtask

  initial begin
    rst                = 1'b0;
    bus.instr_in       = i_type(6'h09, 5'd7, 5'd12, 16'h0);
    bus.pc_in          = 32'h0;
    bus.valid_in       = 1'b1;
    bus.rfReadData_p0  = 32'h0;
    bus.rfReadData_p1  = 32'h0;
    bus.dCacheReadData = 32'h1234_5678;

    // Reset state: valid_in is high but reset holds everything clear.
    repeat (3) tick();
    check("rst.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst.wb_result", bus.wb_result, 32'd0);
    check("rst.we", {31'd0, bus.dCacheWriteEn}, 32'd0);
    check("rst.jump", {31'd0, bus.jump_taken}, 32'd0);
    check("rst.rf_en", {30'd0, bus.rfReadEn_p0, bus.rfReadEn_p1}, 32'd3);
    check("rst.rf_addr", {22'd0, bus.rfReadAddr_p0, bus.rfReadAddr_p1}, {22'd0, 5'd7, 5'd12});
    bus.valid_in = 1'b0;
    rst = 1'b1;
    tick();

    // ADDIU $1,$0,5 -> two bubbles -> ADDU $2,$1,$1
    issue(i_type(6'h09, 5'd0, 5'd1, 16'd5), 32'h100, 32'd0, 32'd0);
    tick(); tick();
    check_wb("addiu", 5'd1, 32'd5, 1'b1);
    check("addiu.m2r", {31'd0, bus.wb_mem_to_reg}, 32'd0);
    issue(r_type(5'd1, 5'd1, 5'd2, 5'd0, 6'h21), 32'h104, 32'd5, 32'd5);
    tick(); tick();
    check_wb("addu", 5'd2, 32'd10, 1'b1);

    // SW $3,8($0)
    issue(i_type(6'h2B, 5'd0, 5'd3, 16'd8), 32'h108, 32'd0, 32'hDEAD_BEEF);
    check("sw.we_ex", {31'd0, bus.dCacheWriteEn}, 32'd0);
    tick();
    check("sw.addr", bus.dCacheAddr, 32'd8);
    check("sw.wdata", bus.dCacheWriteData, 32'hDEAD_BEEF);
    check("sw.we", {31'd0, bus.dCacheWriteEn}, 32'd1);
    check("sw.re", {31'd0, bus.dCacheReadEn}, 32'd0);
    tick();
    check("sw.we_end", {31'd0, bus.dCacheWriteEn}, 32'd0);
    check_wb("sw", 5'd3, 32'd8, 1'b0);
    check("sw.load_data", bus.wb_load_data, 32'd0);

    // LW $4,8($0)
    issue(i_type(6'h23, 5'd0, 5'd4, 16'd8), 32'h10C, 32'd0, 32'd0);
    tick();
    check("lw.re", {31'd0, bus.dCacheReadEn}, 32'd1);
    check("lw.addr", bus.dCacheAddr, 32'd8);
    tick();
    check_wb("lw", 5'd4, 32'd8, 1'b1);
    check("lw.m2r", {31'd0, bus.wb_mem_to_reg}, 32'd1);
    check("lw.data", bus.wb_load_data, 32'h1234_5678);

    // BEQ $1,$1,+3 at pc_in 0x104 -> target 0x110
    issue(i_type(6'h04, 5'd1, 5'd1, 16'd3), 32'h104, 32'd7, 32'd7);
    check("beq.jump", {31'd0, bus.jump_taken}, 32'd0);
    tick();
    check("beq.taken", {31'd0, bus.branch_taken}, 32'd1);
    check("beq.target", bus.branch_target, 32'h110);
    tick();
    check("beq.taken_end", {31'd0, bus.branch_taken}, 32'd0);
    check("beq.reg_write", {31'd0, bus.wb_reg_write}, 32'd0);

    // BNE with equal operands is not taken; unequal with negative offset is.
    issue(i_type(6'h05, 5'd1, 5'd1, 16'd3), 32'h104, 32'd7, 32'd7);
    tick();
    check("bne_eq.taken", {31'd0, bus.branch_taken}, 32'd0);
    issue(i_type(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'h200, 32'd7, 32'd8);
    tick();
    check("bne_ne.taken", {31'd0, bus.branch_taken}, 32'd1);
    check("bne_ne.target", bus.branch_target, 32'h1F8);

    // J 0x40 at pc_in 0x2000_0008
    issue({6'h02, 26'h40}, 32'h2000_0008, 32'd0, 32'd0);
    check("j.taken", {31'd0, bus.jump_taken}, 32'd1);
    check("j.target", bus.jump_target, 32'h2000_0100);
    tick();
    check("j.taken_end", {31'd0, bus.jump_taken}, 32'd0);
    tick();
    check("j.reg_write", {31'd0, bus.wb_reg_write}, 32'd0);

    // Back-to-back: SLT then SLTU of -1 vs 1
    issue(r_type(5'd6, 5'd7, 5'd5, 5'd0, 6'h2A), 32'h300, 32'hFFFF_FFFF, 32'd1);
    issue(r_type(5'd6, 5'd7, 5'd5, 5'd0, 6'h2B), 32'h304, 32'hFFFF_FFFF, 32'd1);
    tick();
    check_wb("slt", 5'd5, 32'd1, 1'b1);
    tick();
    check_wb("sltu", 5'd5, 32'd0, 1'b1);

    // SRA $8,$7,4 ; ADDIU $0,$0,7 ; ORI ; LUI ; SUB ; SLTI ; unknown opcode
    issue(r_type(5'd0, 5'd7, 5'd8, 5'd4, 6'h03), 32'h308, 32'h0, 32'h8000_0000);
    tick(); tick();
    check_wb("sra", 5'd8, 32'hF800_0000, 1'b1);
    issue(i_type(6'h09, 5'd0, 5'd0, 16'd7), 32'h30C, 32'd0, 32'd0);
    tick(); tick();
    check_wb("addiu0", 5'd0, 32'd7, 1'b0);
    issue(i_type(6'h0D, 5'd1, 5'd9, 16'h8001), 32'h310, 32'h0001_0000, 32'd0);
    tick(); tick();
    check_wb("ori", 5'd9, 32'h0001_8001, 1'b1);
    issue(i_type(6'h0F, 5'd0, 5'd10, 16'h1234), 32'h314, 32'h5555_5555, 32'd0);
    tick(); tick();
    check_wb("lui", 5'd10, 32'h1234_0000, 1'b1);
    issue(r_type(5'd1, 5'd2, 5'd11, 5'd0, 6'h22), 32'h318, 32'd3, 32'd5);
    tick(); tick();
    check_wb("sub", 5'd11, 32'hFFFF_FFFE, 1'b1);
    issue(i_type(6'h0A, 5'd1, 5'd12, 16'hFFFF), 32'h31C, 32'hFFFF_FFFE, 32'd0);
    tick(); tick();
    check_wb("slti", 5'd12, 32'd1, 1'b1);
    issue(i_type(6'h3F, 5'd1, 5'd13, 16'h0001), 32'h320, 32'd0, 32'd0);
    tick();
    check("nop.we", {30'd0, bus.dCacheWriteEn, bus.dCacheReadEn}, 32'd0);
    tick();
    check("nop.valid", {31'd0, bus.wb_valid}, 32'd1);
    check("nop.reg_write", {31'd0, bus.wb_reg_write}, 32'd0);

    // Reset while SW is in EX and ADDIU is in MEM
    issue(i_type(6'h09, 5'd0, 5'd14, 16'd9), 32'h400, 32'd0, 32'd0);
    issue(i_type(6'h2B, 5'd0, 5'd3, 16'd16), 32'h404, 32'd0, 32'hCAFE_F00D);
    rst = 1'b0;
    tick();
    check("rst_mid.we", {31'd0, bus.dCacheWriteEn}, 32'd0);
    check("rst_mid.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_mid.wb_reg_write", {31'd0, bus.wb_reg_write}, 32'd0);
    check("rst_mid.wb_result", bus.wb_result, 32'd0);
    check("rst_mid.wb_dest", {27'd0, bus.wb_dest}, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_after.we", {31'd0, bus.dCacheWriteEn}, 32'd0);
    tick();
    check("rst_after.wb_valid", {31'd0, bus.wb_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
